// File: rtl/lcd_stream_timing_gen.sv
// lcd_stream_timing_gen: free-running RGB panel timing with a frame/row-marked pixel queue streamer
module lcd_stream_timing_gen #(
   parameter int H_ACTIVE = 480,
   parameter int H_FP = 50,
   parameter int H_SYNC = 4,
   parameter int H_BP = 25,
   parameter int V_ACTIVE = 272,
   parameter int V_FP = 20,
   parameter int V_SYNC = 2,
   parameter int V_BP = 10,
   parameter bit SYNC_POL = 1'b0,
   parameter int R_BITS = 5,
   parameter int G_BITS = 6,
   parameter int B_BITS = 5,
   parameter int PIX_W = R_BITS + G_BITS + B_BITS,
   parameter logic [PIX_W-1:0] FILL_COLOR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PIX_W:0]    queue_data_in,
   input  logic              queue_empty,
   output logic              queue_rd_en,
   output logic              queue_clk,
   input  logic              test_pattern_en,
   input  logic              clear_status,
   output logic              LCD_DE,
   output logic              LCD_HSYNC,
   output logic              LCD_VSYNC,
   output logic [R_BITS-1:0] LCD_R,
   output logic [G_BITS-1:0] LCD_G,
   output logic [B_BITS-1:0] LCD_B,
   output logic              in_sync,
   output logic [15:0]       underflow_cnt,
   output logic              underflow_flag
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int BAR_W = H_ACTIVE / 8;
   localparam logic [PIX_W:0] FS = {1'b1, PIX_W'(0)};
   localparam logic [PIX_W:0] RS = {1'b1, PIX_W'(1)};
   localparam logic [PIX_W:0] FE = '1;
   typedef enum logic [1:0] {HUNT, ARMED, STREAM} state_t;
   state_t state;
   logic [HW-1:0] h_cnt, bar_raw;
   logic [VW-1:0] v_cnt;
   logic [2:0] bar;
   logic last_h, last_v, v_act, active, h_syn, v_syn, frame_dec, line_start;
   logic px, fs, rs, fe, unk, want, fill;
   logic [PIX_W-1:0] bar_pix, pix_next;
   assign queue_clk = clk;
   assign in_sync = state == STREAM;
   assign last_h = h_cnt == HW'(H_TOTAL - 1);
   assign last_v = v_cnt == VW'(V_TOTAL - 1);
   assign v_act = v_cnt < VW'(V_ACTIVE);
   assign active = h_cnt < HW'(H_ACTIVE) && v_act;
   assign h_syn = h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC);
   assign v_syn = v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC);
   assign frame_dec = last_v && h_cnt == HW'(H_TOTAL - 2);
   assign line_start = last_h && (last_v || v_cnt < VW'(V_ACTIVE - 1));
   assign px = !queue_empty && !queue_data_in[PIX_W];
   assign fs = !queue_empty && queue_data_in == FS;
   assign rs = !queue_empty && queue_data_in == RS;
   assign fe = !queue_empty && queue_data_in == FE;
   assign unk = !queue_empty && queue_data_in[PIX_W] && !fs && !rs && !fe;
   assign want = state == HUNT ? !queue_empty
               : state == ARMED ? 1'b0
               : frame_dec ? fs
               : line_start ? rs
               : active ? px
               : px || unk || (fe && !v_act);
   assign queue_rd_en = want && !reset;
   assign bar_raw = h_cnt / HW'(BAR_W);
   assign bar = bar_raw > HW'(7) ? 3'd7 : bar_raw[2:0];
   assign bar_pix = {{R_BITS{!bar[1]}}, {G_BITS{!bar[2]}}, {B_BITS{!bar[0]}}};
   assign fill = state == STREAM && active && !px && !test_pattern_en;
   assign pix_next = !active ? '0
                   : test_pattern_en ? bar_pix
                   : (state == STREAM && px) ? queue_data_in[PIX_W-1:0]
                   : FILL_COLOR;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
         state <= HUNT;
         LCD_DE <= 1'b0;
         LCD_HSYNC <= !SYNC_POL;
         LCD_VSYNC <= !SYNC_POL;
         {LCD_R, LCD_G, LCD_B} <= '0;
         underflow_cnt <= '0;
         underflow_flag <= 1'b0;
      end else begin
         h_cnt <= last_h ? '0 : h_cnt + 1'b1;
         if (last_h) v_cnt <= last_v ? '0 : v_cnt + 1'b1;
         LCD_DE <= active;
         LCD_HSYNC <= h_syn ~^ SYNC_POL;
         LCD_VSYNC <= v_syn ~^ SYNC_POL;
         {LCD_R, LCD_G, LCD_B} <= pix_next;
         if (state == HUNT && fs) state <= ARMED;
         else if (state == ARMED && frame_dec) state <= STREAM;
         else if (state == STREAM && frame_dec && !fs) state <= HUNT;
         if (clear_status) begin
            underflow_cnt <= '0;
            underflow_flag <= 1'b0;
         end else if (fill) begin
            underflow_cnt <= underflow_cnt + {15'd0, ~&underflow_cnt};
            underflow_flag <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_lcd_stream_timing_gen.sv
// tb_lcd_stream_timing_gen: randomized queue traffic against a cycle-level reference of the panel streamer
module tb_lcd_stream_timing_gen;
   localparam int HA = 16, HF = 3, HS = 2, HB = 3;
   localparam int VA = 6, VF = 2, VS = 1, VB = 2;
   localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = HT * VT;
   localparam logic [16:0] FS = 17'h10000, RS = 17'h10001, FE = 17'h1FFFF, UNK = 17'h10055;
   localparam int M_HUNT = 0, M_ARM = 1, M_STR = 2;
   logic clk = 1'b0, reset = 1'b1, queue_empty = 1'b1, test_pattern_en = 1'b0, clear_status = 1'b0;
   logic [16:0] queue_data_in = '0;
   logic rd0, qc0, de0, hs0, vs0, is0, uf0, rd1, qc1, de1, hs1, vs1, is1, uf1;
   logic [4:0] r0, b0, r1, b1;
   logic [5:0] g0, g1;
   logic [15:0] uc0, uc1;
   logic [16:0] q[$];
   logic [15:0] exp_px[$];
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   int checks = 0, failures = 0;
   int tick, mode, stall_pct = 0, clr_pm = 0;
   bit sb_on = 0, track = 0;
   logic m_de, m_hs, m_vs, m_uf, m_st;
   logic [15:0] m_pix, m_uc;

   always #5 clk = ~clk;

   lcd_stream_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .queue_data_in(queue_data_in), .queue_empty(queue_empty),
      .queue_rd_en(rd0), .queue_clk(qc0), .test_pattern_en(test_pattern_en), .clear_status(clear_status),
      .LCD_DE(de0), .LCD_HSYNC(hs0), .LCD_VSYNC(vs0), .LCD_R(r0), .LCD_G(g0), .LCD_B(b0),
      .in_sync(is0), .underflow_cnt(uc0), .underflow_flag(uf0));

   lcd_stream_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)) dut1 (
      .clk(clk), .reset(reset), .queue_data_in(queue_data_in), .queue_empty(queue_empty),
      .queue_rd_en(rd1), .queue_clk(qc1), .test_pattern_en(test_pattern_en), .clear_status(clear_status),
      .LCD_DE(de1), .LCD_HSYNC(hs1), .LCD_VSYNC(vs1), .LCD_R(r1), .LCD_G(g1), .LCD_B(b1),
      .in_sync(is1), .underflow_cnt(uc1), .underflow_flag(uf1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      tick = 0;
      mode = M_HUNT;
      {m_de, m_hs, m_vs, m_uf, m_st} = '0;
      m_pix = '0;
      m_uc = '0;
   endtask

   // One frame of queue traffic: optional junk and FS, then lines of RS + pixels, then FE.
   task automatic push_frame(input bit with_fs, input int lines, input int short_ln, input int long_ln, input int junk);
      logic [15:0] p;
      for (int j = 0; j < junk; j++) q.push_back(j[0] ? UNK : {1'b0, 16'($urandom)});
      if (with_fs) q.push_back(FS);
      for (int l = 0; l < lines; l++) begin
         q.push_back(RS);
         for (int i = 0; i < HA - (l == short_ln ? 3 : 0) + (l == long_ln ? 3 : 0); i++) begin
            p = 16'($urandom);
            q.push_back({1'b0, p});
            if (track && i < HA) exp_px.push_back(p);
         end
      end
      q.push_back(FE);
   endtask

   task automatic check_outputs();
      chk("de", de0, m_de);
      chk("de_pol1", de1, m_de);
      chk("hsync", hs0, !m_hs);
      chk("vsync", vs0, !m_vs);
      chk("hsync_pol1", hs1, m_hs);
      chk("vsync_pol1", vs1, m_vs);
      chk("pix", {r0, g0, b0}, m_pix);
      chk("pix_pol1", {r1, g1, b1}, m_pix);
      chk("in_sync", is0, mode == M_STR);
      chk("uf_cnt", uc0, m_uc);
      chk("uf_flag", uf0, m_uf);
      if (sb_on && de0 && m_st) chk("sb_pix", {r0, g0, b0}, exp_px.size() ? {16'd0, exp_px.pop_front()} : 32'h1FFFF);
   endtask

   task automatic cycle();
      int h, v, nmode;
      bit emp, px, fs, rs, fe, unk, act, dec, ls, erd, fill;
      logic [16:0] w;
      logic [15:0] npix;
      emp = q.size() == 0 || (stall_pct > 0 && $urandom_range(99) < stall_pct);
      w = q.size() != 0 ? q[0] : 17'h0;
      queue_empty = emp;
      queue_data_in = w;
      clear_status = clr_pm > 0 && $urandom_range(999) < clr_pm;
      #1;
      check_outputs();
      h = tick % HT;
      v = (tick / HT) % VT;
      px = !emp && !w[16];
      fs = !emp && w == FS;
      rs = !emp && w == RS;
      fe = !emp && w == FE;
      unk = !emp && w[16] && !fs && !rs && !fe;
      act = h < HA && v < VA;
      dec = v == VT - 1 && h == HT - 2;
      ls = h == HT - 1 && ((v + 1) % VT) < VA;
      if (mode == M_HUNT) erd = !emp;
      else if (mode == M_ARM) erd = 0;
      else if (dec) erd = fs;
      else if (ls) erd = rs;
      else if (act) erd = px;
      else erd = px || unk || (fe && v >= VA);
      chk("rd_en", rd0, erd);
      chk("rd_en_pol1", rd1, erd);
      fill = mode == M_STR && act && !px && !test_pattern_en;
      npix = !act ? 16'h0 : test_pattern_en ? bars[(h / (HA / 8)) > 7 ? 7 : h / (HA / 8)]
           : (mode == M_STR && px) ? w[15:0] : 16'h0;
      nmode = mode;
      if (mode == M_HUNT && fs) nmode = M_ARM;
      if (mode == M_ARM && dec) nmode = M_STR;
      if (mode == M_STR && dec && !fs) nmode = M_HUNT;
      @(posedge clk);
      if (erd) void'(q.pop_front());
      m_de = act;
      m_hs = h >= HA + HF && h < HA + HF + HS;
      m_vs = v >= VA + VF && v < VA + VF + VS;
      m_pix = npix;
      m_st = mode == M_STR;
      if (clear_status) begin
         m_uc = 0;
         m_uf = 0;
      end else if (fill) begin
         m_uc = m_uc == 16'hFFFF ? m_uc : m_uc + 1;
         m_uf = 1;
      end
      mode = nmode;
      tick++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_status = 1'b0;
      queue_empty = 1'b0;
      queue_data_in = {1'b0, 16'h1234};
      #1;
      chk("rst_de", de0, 0);
      chk("rst_hsync", hs0, 1);
      chk("rst_vsync", vs0, 1);
      chk("rst_hsync_pol1", hs1, 0);
      chk("rst_vsync_pol1", vs1, 0);
      chk("rst_pix", {r0, g0, b0}, 0);
      chk("rst_in_sync", is0, 0);
      chk("rst_uf_cnt", uc0, 0);
      chk("rst_uf_flag", uf0, 0);
      chk("rst_rd_en", rd0, 0);
      chk("queue_clk", qc0, clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      // clean frames after some junk: exact pixel order and no underflow
      track = 1;
      push_frame(1, VA, -1, -1, 3);
      push_frame(1, VA, -1, -1, 0);
      push_frame(1, VA, -1, -1, 0);
      track = 0;
      sb_on = 1;
      run(4 * FRAME);
      sb_on = 0;
      chk("sb_left", exp_px.size(), 0);
      chk("uf_after_clean", uc0, 0);
      // short, long and truncated frames with stalls and clears
      push_frame(1, VA, 2, 4, 0);
      push_frame(1, VA, 5, 1, 2);
      push_frame(1, 4, -1, -1, 0);
      push_frame(1, VA, 0, 3, 0);
      push_frame(1, VA, -1, -1, 0);
      run(FRAME);
      stall_pct = 5;
      clr_pm = 4;
      run(3 * FRAME);
      stall_pct = 0;
      clr_pm = 0;
      // colour bars while the queue keeps draining
      test_pattern_en = 1'b1;
      push_frame(1, VA, -1, -1, 0);
      push_frame(1, VA, -1, -1, 0);
      run(2 * FRAME);
      test_pattern_en = 1'b0;
      // two frames without FS, then resync
      push_frame(0, VA, -1, -1, 1);
      push_frame(0, VA, 1, -1, 0);
      push_frame(1, VA, -1, -1, 0);
      push_frame(1, VA, -1, -1, 0);
      run(5 * FRAME);
      // reset mid-frame then resync on the next FS
      push_frame(1, VA, -1, -1, 0);
      push_frame(1, VA, -1, -1, 0);
      run(FRAME + 3 * HT + 10);
      do_reset();
      push_frame(1, VA, 3, -1, 0);
      push_frame(1, VA, -1, -1, 0);
      run(3 * FRAME);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
